need_level_bank: RTL
====================

Name: need_level_bank

Overview:
- Multi-channel successor to the single-need level counter in the pet-behaviour datapath.
- Tracks N_CH independent need levels (hunger, energy, hygiene, ...). Each level decays on a timebase, is raised by a user request edge, and raises a fixed-length feedback window per channel.
- Adds sleep-mode decay scaling, a critical flag, and aggregate min/all-full outputs for the top-level state machine and display driver.

Parameters:
- N_CH, 4, number of need channels (1..8)
- LEVEL_W, 2, level width; MAX_LEVEL = 2**LEVEL_W-1
- DECAY_TICKS, 15, tick_en pulses per one-level decay in normal mode (>=1)
- SLEEP_MULT, 2, decay period multiplier in sleep mode (>=1)
- FEEDBACK_TICKS, 7, tick_en pulses the feedback window stays high (>=1)

Ports:
- clk  in  1  system clock
- B_reset  in  1  asynchronous, active-high reset
- tick_en  in  1  single-cycle timebase strobe; all timing counts these
- activo  in  1  global enable; 0 freezes decay and ignores requests
- sleep  in  1  1 = decay period DECAY_TICKS*SLEEP_MULT
- req  in  N_CH  per-channel request level (already synchronised)
- level  out  N_CH*LEVEL_W  packed levels, channel i at [i*LEVEL_W +: LEVEL_W]
- feedback  out  N_CH  per-channel window after an accepted request
- critical  out  N_CH  level==0
- min_level  out  LEVEL_W  minimum over all channels
- all_full  out  1  every channel at MAX_LEVEL

Behaviour:
- Reset, applied asynchronously:
  - levels = MAX_LEVEL; decay counters = 0; feedback = 0; feedback counters = 0.
  - req_prev = 0.
  - Resulting outputs: critical = 0, min_level = MAX_LEVEL, all_full = 1.
- Request edge:
  - req_prev[i] registers every clk.
  - Accept = req[i] & ~req_prev[i] & activo. A rising edge while activo=0 is lost, not deferred.
- Accepted request:
  - If level < MAX_LEVEL: level+1 next cycle, decay counter cleared.
  - If level == MAX_LEVEL: level unchanged, decay counter cleared.
  - In both cases feedback[i] rises next cycle and its counter loads 0.
- Feedback:
  - Stays high until FEEDBACK_TICKS tick_en pulses have been counted, then drops on the cycle of the final tick.
  - A new accept while high restarts the window.
  - Counts regardless of activo.
- Decay:
  - Period P = sleep ? DECAY_TICKS*SLEEP_MULT : DECAY_TICKS.
  - When activo & tick_en, the counter increments.
  - When it reaches P-1 on a tick: counter -> 0 and level-1 if level > 0.
  - At level 0 the counter keeps wrapping and the level saturates at 0.
  - A sleep change mid-count does not clear the counter. If the counter already meets or exceeds the new P-1, the next tick decays.
- Simultaneous accept and decay tick, same cycle, same channel: the accept wins (level+1, counter cleared), with no decay.
- activo = 0: levels and decay counters hold.
- Counter widths: clog2(DECAY_TICKS*SLEEP_MULT) and clog2(FEEDBACK_TICKS+1). No overflow is permitted.
- Outputs critical, min_level and all_full are combinational from the registered levels. All other outputs are registered.
- Channels are fully independent. There is no cross-channel priority.

Decomposition:
- Shared package need_pkg holds:
  - localparams MAX_LEVEL and the counter widths, derived from parameters via function helpers.
  - Channel index constants CH_HUNGER=0, CH_ENERGY=1, CH_HYGIENE=2, CH_FUN=3.
- Sub-module need_channel holds one channel: edge detect, level, decay counter and feedback counter.
  - The top generates N_CH instances and holds the min/all_full reduction.

Test Plan:
- Reset: assert B_reset mid-count with level=1 -> asynchronously level=3, feedback=0, all_full=1, min_level=3, critical=0.
- Decay: activo=1, sleep=0, 15 ticks -> ch0 level 3->2. After 45 ticks total, level 0 and critical[0]=1. Further ticks keep level 0.
- Sleep: sleep=1 -> 30 ticks per decrement. Toggle sleep to 0 when the counter is at 20 -> decay on the next tick.
- Request: rising req[1] at level 1 -> level 2 next cycle, feedback[1] high for exactly 7 ticks. Holding req high gives no further increments. A second edge at tick 4 restarts the window.
- Collision and saturation:
  - Req edge on the same cycle as the 15th tick at level 2 -> level 3, decay counter 0.
  - Req at level 3 -> stays 3, feedback pulses.
- activo=0: 100 ticks plus req edges -> levels unchanged, no feedback. Then activo=1 -> resumes from the held counter value.

Source files
------------

// File: rtl/need_pkg.sv
// Shared definitions for the need-level bank: width helpers, default
// derived constants and the channel index map used by the top-level FSM.
package need_pkg;

    // Largest value representable in a level of the given width.
    function automatic int max_level_of(input int level_w);
        return (1 << level_w) - 1;
    endfunction

    // Decay counter width; kept at least one bit wide so a 1-tick period still elaborates.
    function automatic int decay_cnt_w(input int decay_ticks, input int sleep_mult);
        int w;
        w = $clog2(decay_ticks * sleep_mult);
        return (w < 1) ? 1 : w;
    endfunction

    // Feedback counter width, enough to hold FEEDBACK_TICKS.
    function automatic int fb_cnt_w(input int feedback_ticks);
        return $clog2(feedback_ticks + 1);
    endfunction

    localparam int DEF_LEVEL_W        = 2;
    localparam int DEF_DECAY_TICKS    = 15;
    localparam int DEF_SLEEP_MULT     = 2;
    localparam int DEF_FEEDBACK_TICKS = 7;

    localparam int MAX_LEVEL   = max_level_of(DEF_LEVEL_W);
    localparam int DECAY_CNT_W = decay_cnt_w(DEF_DECAY_TICKS, DEF_SLEEP_MULT);
    localparam int FB_CNT_W    = fb_cnt_w(DEF_FEEDBACK_TICKS);

    localparam int CH_HUNGER  = 0;
    localparam int CH_ENERGY  = 1;
    localparam int CH_HYGIENE = 2;
    localparam int CH_FUN     = 3;

endpackage

// File: rtl/need_channel.sv
// One need channel: request edge detect, saturating level with timed decay,
// and a feedback window that restarts on every accepted request.
module need_channel
    import need_pkg::*;
#(
    parameter int LEVEL_W        = 2,
    parameter int DECAY_TICKS    = 15,
    parameter int SLEEP_MULT     = 2,
    parameter int FEEDBACK_TICKS = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_en,
    input  logic               activo,
    input  logic               sleep,
    input  logic               req,
    output logic [LEVEL_W-1:0] level,
    output logic               feedback,
    output logic               critical
);

    localparam int DCW = decay_cnt_w(DECAY_TICKS, SLEEP_MULT);
    localparam int FCW = fb_cnt_w(FEEDBACK_TICKS);

    localparam logic [LEVEL_W-1:0] LVL_MAX     = LEVEL_W'(max_level_of(LEVEL_W));
    localparam logic [DCW-1:0]     LAST_NORMAL = DCW'(DECAY_TICKS - 1);
    localparam logic [DCW-1:0]     LAST_SLEEP  = DCW'(DECAY_TICKS * SLEEP_MULT - 1);
    localparam logic [FCW-1:0]     FB_LAST     = FCW'(FEEDBACK_TICKS - 1);

    logic               req_prev_reg;
    logic [LEVEL_W-1:0] level_reg;
    logic [DCW-1:0]     decay_cnt_reg;
    logic               feedback_reg;
    logic [FCW-1:0]     fb_cnt_reg;

    logic accept;
    logic decay_tick;
    logic decay_due;

    // A rising edge is only honoured while enabled; one seen while disabled is dropped.
    assign accept     = req & ~req_prev_reg & activo;
    assign decay_tick = activo & tick_en;
    // ">=" rather than "==" so a switch to a shorter period with a larger count decays at once.
    assign decay_due  = decay_cnt_reg >= (sleep ? LAST_SLEEP : LAST_NORMAL);

    // Previous request sample for edge detection, tracked regardless of activo.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev_reg <= 1'b0;
        end else begin
            req_prev_reg <= req;
        end
    end

    // Level and decay counter; an accept in the same cycle as a decay tick wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_reg     <= LVL_MAX;
            decay_cnt_reg <= '0;
        end else if (accept) begin
            decay_cnt_reg <= '0;
            if (level_reg != LVL_MAX) begin
                level_reg <= level_reg + LEVEL_W'(1);
            end
        end else if (decay_tick) begin
            if (decay_due) begin
                decay_cnt_reg <= '0;
                if (level_reg != '0) begin
                    level_reg <= level_reg - LEVEL_W'(1);
                end
            end else begin
                decay_cnt_reg <= decay_cnt_reg + DCW'(1);
            end
        end
    end

    // Feedback window: opens on accept, closes on the FEEDBACK_TICKS-th tick, ignores activo.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feedback_reg <= 1'b0;
            fb_cnt_reg   <= '0;
        end else if (accept) begin
            feedback_reg <= 1'b1;
            fb_cnt_reg   <= '0;
        end else if (feedback_reg && tick_en) begin
            if (fb_cnt_reg == FB_LAST) begin
                feedback_reg <= 1'b0;
                fb_cnt_reg   <= '0;
            end else begin
                fb_cnt_reg <= fb_cnt_reg + FCW'(1);
            end
        end
    end

    assign level    = level_reg;
    assign feedback = feedback_reg;
    assign critical = (level_reg == '0);

endmodule

// File: rtl/need_level_bank.sv
// Bank of independent need channels plus the aggregate min / all-full view
// consumed by the behaviour state machine and the display driver.
module need_level_bank
    import need_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int LEVEL_W        = 2,
    parameter int DECAY_TICKS    = 15,
    parameter int SLEEP_MULT     = 2,
    parameter int FEEDBACK_TICKS = 7
) (
    input  logic                    clk,
    input  logic                    B_reset,
    input  logic                    tick_en,
    input  logic                    activo,
    input  logic                    sleep,
    input  logic [N_CH-1:0]         req,
    output logic [N_CH*LEVEL_W-1:0] level,
    output logic [N_CH-1:0]         feedback,
    output logic [N_CH-1:0]         critical,
    output logic [LEVEL_W-1:0]      min_level,
    output logic                    all_full
);

    localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(max_level_of(LEVEL_W));

    logic [LEVEL_W-1:0] ch_level [N_CH];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            need_channel #(
                .LEVEL_W        (LEVEL_W),
                .DECAY_TICKS    (DECAY_TICKS),
                .SLEEP_MULT     (SLEEP_MULT),
                .FEEDBACK_TICKS (FEEDBACK_TICKS)
            ) u_channel (
                .clk      (clk),
                .rst      (B_reset),
                .tick_en  (tick_en),
                .activo   (activo),
                .sleep    (sleep),
                .req      (req[gi]),
                .level    (ch_level[gi]),
                .feedback (feedback[gi]),
                .critical (critical[gi])
            );
            assign level[gi*LEVEL_W +: LEVEL_W] = ch_level[gi];
        end
    endgenerate

    // Aggregate reduction over the registered channel levels.
    always_comb begin
        min_level = LVL_MAX;
        all_full  = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_level[i] < min_level) begin
                min_level = ch_level[i];
            end
            if (ch_level[i] != LVL_MAX) begin
                all_full = 1'b0;
            end
        end
    end

endmodule
